// File: rtl/cla_pkg.sv
// Shared defaults and sizing helpers for the pipelined
// carry-lookahead adder/subtractor.
package cla_pkg;

    localparam int CLA_WIDTH = 32;
    localparam int CLA_GROUP = 4;

    // Number of lookahead groups across the operand width.
    function automatic int cla_groups(input int width, input int group);
        return width / group;
    endfunction

endpackage

// File: rtl/cla_group_gp.sv
// One carry-lookahead group: bitwise propagate/generate plus
// the group-level generate and propagate terms.
module cla_group_gp
    import cla_pkg::*;
#(
    parameter int GROUP = CLA_GROUP
) (
    input  logic [GROUP-1:0] a_i,
    input  logic [GROUP-1:0] b_i,
    output logic [GROUP-1:0] p_o,
    output logic [GROUP-1:0] g_o,
    output logic             gg_o,
    output logic             pg_o
);

    logic [GROUP-1:0] p_v;
    logic [GROUP-1:0] g_v;
    logic             gg_v;

    // Bitwise terms and group G folded from LSB to MSB.
    always_comb begin
        p_v  = a_i ^ b_i;
        g_v  = a_i & b_i;
        gg_v = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            gg_v = g_v[i] | (p_v[i] & gg_v);
        end
    end

    assign p_o  = p_v;
    assign g_o  = g_v;
    assign gg_o = gg_v;
    assign pg_o = &p_v;

endmodule

// File: rtl/cla_pipe_addsub.sv
// Two-stage add/subtract: S1 captures lookahead terms,
// S2 resolves carries and registers the result and flags.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int GROUP = CLA_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = cla_groups(WIDTH, GROUP);

    if ((WIDTH % GROUP) != 0) begin : g_chk_mod
        $error("cla_pipe_addsub: WIDTH must be a multiple of GROUP");
    end
    if (GROUP != 2 && GROUP != 4 && GROUP != 8) begin : g_chk_grp
        $error("cla_pipe_addsub: GROUP must be 2, 4 or 8");
    end
    if (WIDTH < 8 || WIDTH > 128) begin : g_chk_wid
        $error("cla_pipe_addsub: WIDTH must be in 8..128");
    end

    // Flat sum-of-products group carries: each one is built
    // straight from G/P and c0, never from a neighbour carry.
    function automatic logic [NG:0] lookahead(
        input logic [NG-1:0] gg,
        input logic [NG-1:0] pg,
        input logic          c0
    );
        logic [NG:0] c;
        logic        term;
        c    = '0;
        c[0] = c0;
        for (int k = 1; k <= NG; k++) begin
            term = c0;
            for (int m = 0; m < k; m++) begin
                term = term & pg[m];
            end
            c[k] = term;
            for (int j = 0; j < k; j++) begin
                term = gg[j];
                for (int m = j + 1; m < k; m++) begin
                    term = term & pg[m];
                end
                c[k] = c[k] | term;
            end
        end
        return c;
    endfunction

    logic s1_valid_q;
    logic s2_valid_q;
    logic s2_ready;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] g_d;
    logic [NG-1:0]    gg_d;
    logic [NG-1:0]    pg_d;
    logic             cin_d;

    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] g_q;
    logic [NG-1:0]    gg_q;
    logic [NG-1:0]    pg_q;
    logic             cin_q;

    logic [NG:0]      gc;
    logic [WIDTH-1:0] bc;
    logic             cc;

    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             zero_d;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    // Subtract is a + ~b + 1, so the +1 rides on carry-in.
    assign b_eff = sub ? ~b : b;
    assign cin_d = sub | cin;

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        cla_group_gp #(
            .GROUP(GROUP)
        ) u_gp (
            .a_i (a[gi*GROUP +: GROUP]),
            .b_i (b_eff[gi*GROUP +: GROUP]),
            .p_o (p_d[gi*GROUP +: GROUP]),
            .g_o (g_d[gi*GROUP +: GROUP]),
            .gg_o(gg_d[gi]),
            .pg_o(pg_d[gi])
        );
    end

    // A stage may load when it is empty or its content moves on.
    assign s2_ready = ~s2_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | s2_ready;

    // S1: capture operand-derived lookahead terms.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            p_q        <= '0;
            g_q        <= '0;
            gg_q       <= '0;
            pg_q       <= '0;
            cin_q      <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                p_q   <= p_d;
                g_q   <= g_d;
                gg_q  <= gg_d;
                pg_q  <= pg_d;
                cin_q <= cin_d;
            end
        end
    end

    // S2 combinational: group carries, then in-group carries.
    always_comb begin
        gc = lookahead(gg_q, pg_q, cin_q);
        bc = '0;
        cc = 1'b0;
        for (int k = 0; k < NG; k++) begin
            cc = gc[k];
            for (int i = 0; i < GROUP; i++) begin
                bc[k*GROUP+i] = cc;
                cc = g_q[k*GROUP+i] | (p_q[k*GROUP+i] & cc);
            end
        end
        sum_d  = p_q ^ bc;
        cout_d = gc[NG];
        ovf_d  = bc[WIDTH-1] ^ gc[NG];
        zero_d = ~|sum_d;
    end

    // S2: result register, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else if (s2_ready) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
